// File: rtl/riscv_consts.sv
// Shared RISC-V constants for the pipeline: reset vector, injected NOP, fetch regions, opcodes.
// Latency: none (package only).
// Backpressure: not applicable.
package riscv_consts;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;  // BIOS base
  localparam logic [31:0] NOP      = 32'h0000_0013;  // ADDI x0,x0,0

  // Address region codes, decoded from PC[31:28]
  localparam logic [3:0] REGION_BIOS = 4'b0100;
  localparam logic [3:0] REGION_IMEM = 4'b0001;

  // Major opcodes used by the controller
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ARITHI = 7'b0010011;
  localparam logic [6:0] OPC_ARITH  = 7'b0110011;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;

endpackage

// File: rtl/fetch_stage_src_mux.sv
// Region decode of the IF/D PC, read-data select and NOP injection for killed slots.
// Latency: combinational.
// Backpressure: none; inputs are held stable by the PC register during stalls.
// Ports: pc_region = PC[31:28]; valid_q/redirect feed the kill; bios_dout/imem_dout are
//        the RAM words; inst/inst_valid go to decode; unmapped flags a fetch outside BIOS/IMEM.
module fetch_src_mux
  import riscv_consts::*;
(
  input  logic [3:0]  pc_region,
  input  logic        valid_q,
  input  logic        redirect,
  input  logic [31:0] bios_dout,
  input  logic [31:0] imem_dout,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        unmapped
);

  logic [31:0] sel_dout;
  logic        kill;

  always_comb begin
    sel_dout = NOP;
    unmapped = 1'b0;
    case (pc_region)
      REGION_BIOS: sel_dout = bios_dout;
      REGION_IMEM: sel_dout = imem_dout;
      default:     unmapped = 1'b1;
    endcase
  end

  // A redirect kills the fall-through word already sitting in IF/D in the same cycle.
  assign kill       = redirect | ~valid_q | unmapped;
  assign inst       = kill ? NOP : sel_dout;
  assign inst_valid = ~kill;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RAM address generation, redirect/stall handling, issue counter.
// Latency: address issued at cycle t returns data at t+1, when pc_q equals that address.
// Backpressure: stall reissues pc_q so RAM data and id_inst hold; redirect overrides stall.
// Ports: clk/rst (sync, active high); stall, redirect, redirect_pc from the pipeline;
//        bios_addr/imem_addr out and bios_dout/imem_dout in for the RAMs; id_pc/id_inst/id_valid
//        to decode; fetch_fault sticky unmapped-fetch flag; inst_count issued-instruction count.
module fetch_stage
  import riscv_consts::*;
#(
  parameter int IMEM_AW = 14,
  parameter int BIOS_AW = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [BIOS_AW-1:0] bios_addr,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        bios_dout,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_inst,
  output logic               id_valid,
  output logic               fetch_fault,
  output logic [31:0]        inst_count
);

  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        valid_q;
  logic        unmapped;

  // PC is also held while valid_q is low: the RAM word for RESET_PC arrives in the
  // first cycle after reset, gets killed there, and must be re-read so BIOS word 0
  // is actually executed one cycle later.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (rst)
      next_pc = RESET_PC;
    else if (redirect)
      next_pc = redirect_pc & 32'hFFFF_FFFC;
    else if (stall || !valid_q)
      next_pc = pc_q;
  end

  assign bios_addr = next_pc[BIOS_AW+1:2];
  assign imem_addr = next_pc[IMEM_AW+1:2];
  assign id_pc     = pc_q;

  fetch_src_mux u_src_mux (
    .pc_region  (pc_q[31:28]),
    .valid_q    (valid_q),
    .redirect   (redirect),
    .bios_dout  (bios_dout),
    .imem_dout  (imem_dout),
    .inst       (id_inst),
    .inst_valid (id_valid),
    .unmapped   (unmapped)
  );

  always_ff @(posedge clk) begin
    pc_q <= next_pc;
    if (rst) begin
      valid_q     <= 1'b0;
      fetch_fault <= 1'b0;
      inst_count  <= 32'd0;
    end else begin
      valid_q <= 1'b1;
      // A redirect away from an unmapped PC is a legitimate wrong-path fetch, not a fault.
      if (valid_q && unmapped && !redirect)
        fetch_fault <= 1'b1;
      if (id_valid && !stall)
        inst_count <= inst_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int IMEM_AW = 14;
  localparam int BIOS_AW = 12;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [BIOS_AW-1:0] bios_addr;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        bios_dout = 32'd0;
  logic [31:0]        imem_dout = 32'd0;
  logic [31:0]        id_pc;
  logic [31:0]        id_inst;
  logic               id_valid;
  logic               fetch_fault;
  logic [31:0]        inst_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.IMEM_AW(IMEM_AW), .BIOS_AW(BIOS_AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bios_addr   (bios_addr),
    .imem_addr   (imem_addr),
    .bios_dout   (bios_dout),
    .imem_dout   (imem_dout),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_valid    (id_valid),
    .fetch_fault (fetch_fault),
    .inst_count  (inst_count)
  );

  // Memory contents are a fixed function of word address so expectations are easy to write.
  function automatic logic [31:0] bios_word(input int a);
    return (a == 0) ? 32'h0010_0093 : (32'h0BA0_0000 + 32'(a));
  endfunction
  function automatic logic [31:0] imem_word(input int a);
    return 32'h1ACE_0000 + 32'(a);
  endfunction

  // Synchronous-read RAM models.
  always @(posedge clk) begin
    bios_dout <= bios_word(int'(bios_addr));
    imem_dout <= imem_word(int'(imem_addr));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven, outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_is(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                       input logic vld);
    chk({tag, ".pc"}, id_pc, pc);
    chk({tag, ".inst"}, id_inst, inst);
    chk({tag, ".valid"}, 32'(id_valid), 32'(vld));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    tick(); tick();
    #1;
    // In reset
    id_is("rst", RST_PC, NOP_W, 1'b0);
    chk("rst.fault", 32'(fetch_fault), 32'd0);
    chk("rst.count", inst_count, 32'd0);
    chk("rst.baddr", 32'(bios_addr), 32'd0);

    // First cycle after release: word 0 is on dout but killed
    rst = 1'b0; #1;
    id_is("rel1", RST_PC, NOP_W, 1'b0);
    chk("rel1.baddr", 32'(bios_addr), 32'd0);

    tick(); #1;
    id_is("rel2", RST_PC, 32'h0010_0093, 1'b1);
    chk("rel2.count", inst_count, 32'd0);
    chk("rel2.baddr", 32'(bios_addr), 32'd1);

    tick(); #1;
    id_is("seq1", 32'h4000_0004, bios_word(1), 1'b1);
    chk("seq1.count", inst_count, 32'd1);
    chk("seq1.baddr", 32'(bios_addr), 32'd2);

    // Stall for 3 cycles at 4000_0008
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      stall = 1'b1; #1;
      id_is("stall", 32'h4000_0008, bios_word(2), 1'b1);
      chk("stall.baddr", 32'(bios_addr), 32'd2);
      chk("stall.count", inst_count, 32'd2);
    end
    tick();
    stall = 1'b0; #1;
    id_is("unstall", 32'h4000_0008, bios_word(2), 1'b1);
    chk("unstall.count", inst_count, 32'd2);
    chk("unstall.baddr", 32'(bios_addr), 32'd3);

    tick(); #1;
    id_is("seq2", 32'h4000_000C, bios_word(3), 1'b1);
    chk("seq2.count", inst_count, 32'd3);

    // Redirect to IMEM with misaligned target
    tick();
    redirect = 1'b1; redirect_pc = 32'h1000_0102; #1;
    id_is("redir", 32'h4000_0010, NOP_W, 1'b0);
    chk("redir.iaddr", 32'(imem_addr), 32'h40);
    chk("redir.count", inst_count, 32'd4);

    tick();
    redirect = 1'b0; #1;
    id_is("tgt", 32'h1000_0100, imem_word(32'h40), 1'b1);
    chk("tgt.count", inst_count, 32'd4);

    tick(); #1;
    id_is("tgt1", 32'h1000_0104, imem_word(32'h41), 1'b1);
    chk("tgt1.count", inst_count, 32'd5);

    // Stall and redirect together: redirect wins
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h4000_0100; #1;
    id_is("sr", 32'h1000_0104, NOP_W, 1'b0);
    chk("sr.baddr", 32'(bios_addr), 32'h40);

    tick();
    stall = 1'b0; redirect = 1'b0; #1;
    id_is("sr_tgt", 32'h4000_0100, bios_word(32'h40), 1'b1);
    chk("sr_tgt.count", inst_count, 32'd5);

    // Two consecutive redirects
    tick();
    redirect = 1'b1; redirect_pc = 32'h1000_0000; #1;
    id_is("dr1", 32'h4000_0104, NOP_W, 1'b0);
    chk("dr1.count", inst_count, 32'd6);

    tick();
    redirect_pc = 32'h4000_0202; #1;
    id_is("dr2", 32'h1000_0000, NOP_W, 1'b0);
    chk("dr2.baddr", 32'(bios_addr), 32'h80);

    tick();
    redirect = 1'b0; #1;
    id_is("dr_tgt", 32'h4000_0200, bios_word(32'h80), 1'b1);
    chk("dr_tgt.count", inst_count, 32'd6);

    // Unmapped fetch and sticky fault
    tick();
    redirect = 1'b1; redirect_pc = 32'h2000_0000; #1;
    chk("um0.count", inst_count, 32'd7);
    chk("um0.fault", 32'(fetch_fault), 32'd0);

    tick();
    redirect = 1'b0; #1;
    id_is("um1", 32'h2000_0000, NOP_W, 1'b0);

    tick();
    redirect = 1'b1; redirect_pc = RST_PC; #1;
    chk("um2.fault", 32'(fetch_fault), 32'd1);
    chk("um2.count", inst_count, 32'd7);

    tick();
    redirect = 1'b0; #1;
    id_is("back", RST_PC, 32'h0010_0093, 1'b1);
    chk("back.fault", 32'(fetch_fault), 32'd1);

    // PC+4 wraps from the top of the address space to an unmapped 0
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    chk("wrap0.count", inst_count, 32'd8);

    tick();
    redirect = 1'b0; #1;
    id_is("wrap1", 32'hFFFF_FFFC, NOP_W, 1'b0);

    tick(); #1;
    id_is("wrap2", 32'h0000_0000, NOP_W, 1'b0);
    chk("wrap2.fault", 32'(fetch_fault), 32'd1);

    // Reset mid-operation
    rst = 1'b1; #1;
    chk("mrst.baddr", 32'(bios_addr), 32'd0);

    tick(); #1;
    id_is("mrst", RST_PC, NOP_W, 1'b0);
    chk("mrst.fault", 32'(fetch_fault), 32'd0);
    chk("mrst.count", inst_count, 32'd0);

    rst = 1'b0; #1;
    id_is("mrel1", RST_PC, NOP_W, 1'b0);

    tick(); #1;
    id_is("mrel2", RST_PC, 32'h0010_0093, 1'b1);

    tick(); #1;
    chk("mrel3.count", inst_count, 32'd1);
    chk("mrel3.pc", id_pc, 32'h4000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
